// File: rtl/hack_quadrature_encoder.sv
// Quadrature signal generator: emits a commanded number of Gray-code edges
// on out_a/out_b at one edge per STEP_DIV clocks, tracking a net position.
module hack_quadrature_encoder #(
  parameter int unsigned STEP_DIV  = 1000,
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_dir,
  input  logic [CNT_WIDTH-1:0] cmd_count,
  output logic                 out_a,
  output logic                 out_b,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] position
);

  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(STEP_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t               state, state_nx;
  logic [1:0]           phase, phase_nx;
  logic                 dir, dir_nx;
  logic [CNT_WIDTH-1:0] remaining, remaining_nx;
  logic [DIV_WIDTH-1:0] divider, divider_nx;
  logic [CNT_WIDTH-1:0] position_nx;
  logic                 a_nx, b_nx;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      phase     <= 2'd0;
      dir       <= 1'b0;
      remaining <= '0;
      divider   <= '0;
      position  <= '0;
      out_a     <= 1'b0;
      out_b     <= 1'b0;
    end else begin
      state     <= state_nx;
      phase     <= phase_nx;
      dir       <= dir_nx;
      remaining <= remaining_nx;
      divider   <= divider_nx;
      position  <= position_nx;
      out_a     <= a_nx;
      out_b     <= b_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    phase_nx     = phase;
    dir_nx       = dir;
    remaining_nx = remaining;
    divider_nx   = divider;
    position_nx  = position;
    cmd_ready    = (state == IDLE);

    case (state)
      IDLE: begin
        // A zero-count command is consumed here without leaving IDLE.
        if (cmd_valid && (cmd_count != '0)) begin
          dir_nx       = cmd_dir;
          remaining_nx = cmd_count;
          divider_nx   = '0;
          state_nx     = RUN;
        end
      end
      RUN: begin
        if (divider == DIV_LAST) begin
          divider_nx   = '0;
          phase_nx     = dir ? phase + 2'd1 : phase - 2'd1;
          position_nx  = dir ? position + CNT_ONE : position - CNT_ONE;
          remaining_nx = remaining - CNT_ONE;
          if (remaining == CNT_ONE) state_nx = IDLE;
        end else begin
          divider_nx = divider + DIV_ONE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Outputs are registered from the next phase so no decode sits after the flops.
    case (phase_nx)
      2'd0:    {a_nx, b_nx} = 2'b00;
      2'd1:    {a_nx, b_nx} = 2'b10;
      2'd2:    {a_nx, b_nx} = 2'b11;
      default: {a_nx, b_nx} = 2'b01;
    endcase
  end

  assign busy = ~cmd_ready;

endmodule

// File: tb/tb_hack_quadrature_encoder.sv
// Directed self-checking bench for hack_quadrature_encoder with STEP_DIV=4.
module tb_hack_quadrature_encoder;

  localparam int SD = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [7:0] cmd_count;
  logic       out_a;
  logic       out_b;
  logic       busy;
  logic [7:0] position;

  int total = 0;
  int bad   = 0;

  logic [1:0] m_p;
  logic [7:0] m_pos;

  always #5 clock = ~clock;

  hack_quadrature_encoder #(
    .STEP_DIV (SD),
    .DIV_WIDTH(16),
    .CNT_WIDTH(8)
  ) u_dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir  (cmd_dir),
    .cmd_count(cmd_count),
    .out_a    (out_a),
    .out_b    (out_b),
    .busy     (busy),
    .position (position)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [1:0] gray_of(input logic [1:0] p);
    case (p)
      2'd0:    return 2'b00;
      2'd1:    return 2'b10;
      2'd2:    return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_ab"},    32'({out_a, out_b}), 32'(gray_of(m_p)));
    chk({tag, "_pos"},   32'(position), 32'(m_pos));
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  // poke_at: cycle to present a stray command while busy; abort_at: stop early.
  task automatic run_cmd(input logic dir, input int n, input int poke_at, input int abort_at);
    chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_dir   = dir;
    cmd_count = 8'(n);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_count = 8'd0;
    for (int c = 1; c <= n * SD; c++) begin
      if (c == poke_at) begin
        cmd_valid = 1'b1;
        cmd_count = 8'd7;
        cmd_dir   = ~dir;
      end
      tick();
      cmd_valid = 1'b0;
      cmd_count = 8'd0;
      if (c % SD == 0) begin
        m_p   = dir ? m_p + 2'd1 : m_p - 2'd1;
        m_pos = dir ? m_pos + 8'd1 : m_pos - 8'd1;
      end
      chk("run_ab",    32'({out_a, out_b}), 32'(gray_of(m_p)));
      chk("run_pos",   32'(position), 32'(m_pos));
      chk("run_ready", 32'(cmd_ready), (c == n * SD) ? 32'd1 : 32'd0);
      chk("run_busy",  32'(busy), (c == n * SD) ? 32'd0 : 32'd1);
      if (c == abort_at) break;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_count = 8'd0;
    m_p       = 2'd0;
    m_pos     = 8'd0;

    tick();
    tick();
    chk("rst_a",     32'(out_a), 32'd0);
    chk("rst_b",     32'(out_b), 32'd0);
    chk("rst_pos",   32'(position), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy",  32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();

    // CW x4 from phase 0: 10,11,01,00, position 1..4
    run_cmd(1'b1, 4, 0, 0);
    chk("cw4_end_ab",  32'({out_a, out_b}), 32'(2'b00));
    chk("cw4_end_pos", 32'(position), 32'd4);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_p   = 2'd0;
    m_pos = 8'd0;
    chk_idle("rst2");

    // CCW x1 wraps position to 255, then CW x2 back to 1
    run_cmd(1'b0, 1, 0, 0);
    chk("ccw_wrap_ab",  32'({out_a, out_b}), 32'(2'b01));
    chk("ccw_wrap_pos", 32'(position), 32'd255);
    run_cmd(1'b1, 2, 0, 0);
    chk("cw2_ab",  32'({out_a, out_b}), 32'(2'b10));
    chk("cw2_pos", 32'(position), 32'd1);

    // Back-to-back zero-count commands
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_count = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("zero_cmd");
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_idle("zero_after");
    end

    // CW x3 with a stray count=7 command presented while busy
    run_cmd(1'b1, 3, 2, 0);
    chk("busy_ign_ab",  32'({out_a, out_b}), 32'(2'b00));
    chk("busy_ign_pos", 32'(position), 32'd4);
    for (int i = 0; i < 3 * SD; i++) begin
      tick();
      chk_idle("busy_ign_after");
    end

    // CW x10, reset after 5 edges
    run_cmd(1'b1, 10, 0, 5 * SD);
    chk("mid_ab",  32'({out_a, out_b}), 32'(2'b10));
    chk("mid_pos", 32'(position), 32'd9);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_p   = 2'd0;
    m_pos = 8'd0;
    chk_idle("mid_rst");
    for (int i = 0; i < 3 * SD; i++) begin
      tick();
      chk_idle("mid_rst_after");
    end

    // Reset and command in the same cycle: reset wins
    reset_n   = 1'b0;
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_count = 8'd2;
    tick();
    reset_n   = 1'b1;
    cmd_valid = 1'b0;
    cmd_count = 8'd0;
    for (int i = 0; i < 3 * SD; i++) begin
      tick();
      chk_idle("rst_vs_cmd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
